// File: rtl/conv_pkg.sv
// Shared widths and helpers for the streaming 2.5-D convolution datapath.
package conv_pkg;

  localparam int unsigned PIXEL_W  = 8;
  localparam int unsigned WEIGHT_W = 8;
  localparam int unsigned ACC_W    = 32;

  // Ceiling log2, used for adder-tree depths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/conv_mult_adder_tree.sv
// One kernel-channel dot product: registered multipliers feeding a registered binary adder tree.
module conv_mult_adder_tree
  import conv_pkg::*;
#(
  parameter int unsigned MA_TREE_SIZE = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [PIXEL_W*MA_TREE_SIZE-1:0]     pixels,
  input  logic [WEIGHT_W*MA_TREE_SIZE-1:0]    weights,
  output logic signed [ACC_W-1:0]             sum
);

  localparam int unsigned PROD_W = PIXEL_W + 1 + WEIGHT_W;
  localparam int unsigned NODES  = 2*MA_TREE_SIZE - 1;

  logic signed [PROD_W-1:0] px     [MA_TREE_SIZE];
  logic signed [PROD_W-1:0] wt     [MA_TREE_SIZE];
  logic signed [PROD_W-1:0] prod_c [MA_TREE_SIZE];
  logic signed [ACC_W-1:0]  node   [NODES];

  // Pixels are unsigned (zero-extended), weights are signed (sign-extended).
  always_comb begin
    for (int j = 0; j < MA_TREE_SIZE; j++) begin
      px[j]     = PROD_W'($signed({1'b0, pixels[j*PIXEL_W +: PIXEL_W]}));
      wt[j]     = PROD_W'($signed(weights[j*WEIGHT_W +: WEIGHT_W]));
      prod_c[j] = px[j] * wt[j];
    end
  end

  // Heap layout: leaves hold registered products, node k sums nodes 2k+1 and 2k+2.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NODES; k++) node[k] <= '0;
    end else begin
      for (int k = 0; k < MA_TREE_SIZE - 1; k++) node[k] <= node[2*k+1] + node[2*k+2];
      for (int j = 0; j < MA_TREE_SIZE; j++) node[MA_TREE_SIZE-1+j] <= ACC_W'(prod_c[j]);
    end
  end

  assign sum = node[0];

endmodule

// File: rtl/convolution_2_5d.sv
// Streaming 2.5-D convolution: per-channel line shift registers, per-(kernel, channel) trees,
// and a registered cross-channel adder tree per kernel.
module convolution_2_5d
  import conv_pkg::*;
#(
  parameter int unsigned NUM_TREES    = 2,
  parameter int unsigned Z_DEPTH      = 4,
  parameter int unsigned P_SR_DEPTH   = 4,
  parameter int unsigned RAM_SR_DEPTH = 2,
  parameter int unsigned NUM_SR_ROWS  = 4,
  parameter int unsigned MA_TREE_SIZE = 16,
  parameter int unsigned PAD_SIZE     = 0
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [PIXEL_W*Z_DEPTH-1:0]                        pixel_vector_in,
  input  logic [WEIGHT_W*NUM_TREES*MA_TREE_SIZE*Z_DEPTH-1:0] kernel,
  output logic [ACC_W*NUM_TREES-1:0]                        pixel_vector_out
);

  localparam int unsigned ROW_W  = P_SR_DEPTH + RAM_SR_DEPTH;
  localparam int unsigned SR_LEN = NUM_SR_ROWS*P_SR_DEPTH + (NUM_SR_ROWS-1)*RAM_SR_DEPTH;
  localparam int unsigned TAPS_W = PIXEL_W*MA_TREE_SIZE;
  localparam int unsigned KERN_W = WEIGHT_W*MA_TREE_SIZE;

  // Only unpadded operation exists; any other PAD_SIZE yields a constant-zero output.
  if (PAD_SIZE == 0) begin : g_conv
    logic [PIXEL_W-1:0] sr  [Z_DEPTH][SR_LEN];
    logic [TAPS_W-1:0]  win [Z_DEPTH];

    // Free-running line chain; index 0 is the newest pixel.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int z = 0; z < Z_DEPTH; z++)
          for (int k = 0; k < SR_LEN; k++) sr[z][k] <= '0;
      end else begin
        for (int z = 0; z < Z_DEPTH; z++) begin
          sr[z][0] <= pixel_vector_in[z*PIXEL_W +: PIXEL_W];
          for (int k = 1; k < SR_LEN; k++) sr[z][k] <= sr[z][k-1];
        end
      end
    end

    // Tap j: row j/P from the newest row, column j%P from the newest pixel.
    always_comb begin
      for (int z = 0; z < Z_DEPTH; z++) begin
        win[z] = '0;
        for (int j = 0; j < MA_TREE_SIZE; j++)
          win[z][j*PIXEL_W +: PIXEL_W] = sr[z][(j/P_SR_DEPTH)*ROW_W + (j%P_SR_DEPTH)];
      end
    end

    for (genvar t = 0; t < NUM_TREES; t++) begin : g_tree
      logic [ACC_W*Z_DEPTH-1:0] ch_sum;

      for (genvar z = 0; z < Z_DEPTH; z++) begin : g_chan
        conv_mult_adder_tree #(.MA_TREE_SIZE(MA_TREE_SIZE)) u_tree (
          .clock   (clock),
          .reset   (reset),
          .pixels  (win[z]),
          .weights (kernel[((z*NUM_TREES)+t)*KERN_W +: KERN_W]),
          .sum     (ch_sum[z*ACC_W +: ACC_W])
        );
      end

      if (Z_DEPTH == 1) begin : g_flat
        assign pixel_vector_out[t*ACC_W +: ACC_W] = ch_sum;
      end else begin : g_ztree
        logic signed [ACC_W-1:0] zr [Z_DEPTH-1];
        logic signed [ACC_W-1:0] zv [2*Z_DEPTH-1];

        // Heap view: internal nodes are registers, leaves are the channel-tree sums.
        always_comb begin
          for (int k = 0; k < Z_DEPTH - 1; k++) zv[k] = zr[k];
          for (int z = 0; z < Z_DEPTH; z++) zv[Z_DEPTH-1+z] = $signed(ch_sum[z*ACC_W +: ACC_W]);
        end

        always_ff @(posedge clock) begin
          if (reset) begin
            for (int k = 0; k < Z_DEPTH - 1; k++) zr[k] <= '0;
          end else begin
            for (int k = 0; k < Z_DEPTH - 1; k++) zr[k] <= zv[2*k+1] + zv[2*k+2];
          end
        end

        assign pixel_vector_out[t*ACC_W +: ACC_W] = zr[0];
      end
    end
  end else begin : g_no_pad
    assign pixel_vector_out = '0;
  end

endmodule

// File: tb/tb_convolution_2_5d.sv
// Scoreboard bench for convolution_2_5d at Z_DEPTH=4, Z_DEPTH=2 and Z_DEPTH=1 (single tree).
module tb_convolution_2_5d;
  import conv_pkg::*;

  localparam int MA     = 16;
  localparam int P      = 4;
  localparam int ROW_W  = 6;
  localparam int SR_LEN = 22;
  localparam int LAT4   = 1 + int'(clog2(16)) + int'(clog2(4));
  localparam int LAT2   = 1 + int'(clog2(16)) + int'(clog2(2));
  localparam int LAT1   = 1 + int'(clog2(16));

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic [7:0]    pix;
  int            mode;
  logic [31:0]   pv4;
  logic [15:0]   pv2;
  logic [7:0]    pv1;
  logic [1023:0] k4;
  logic [511:0]  k2;
  logic [127:0]  k1;
  logic [63:0]   o4, o2;
  logic [31:0]   o1;

  int hist [SR_LEN];
  int q40[$], q41[$], q20[$], q21[$], q10[$];
  int checks, errors, cyc;

  assign pv4 = {4{pix}};
  assign pv2 = {2{pix}};
  assign pv1 = pix;

  // mode 0: test-pattern kernels; mode 1: all weights -1.
  function automatic int weight(int m, int t, int z, int j);
    int r, c;
    r = j / P;
    c = j % P;
    if (m == 1) return -1;
    if (t == 0) begin
      if (z != 0) return 3;
      if (r < 2) return (c < 2) ? 2 : -1;
      return (c < 2) ? -1 : 2;
    end
    if (z != 0) return 4;
    return (c < 2) ? 2 : 3;
  endfunction

  always_comb begin
    k4 = '0;
    k2 = '0;
    k1 = '0;
    for (int t = 0; t < 2; t++)
      for (int z = 0; z < 4; z++)
        for (int j = 0; j < MA; j++) k4[((z*2+t)*MA+j)*8 +: 8] = 8'(weight(mode, t, z, j));
    for (int t = 0; t < 2; t++)
      for (int z = 0; z < 2; z++)
        for (int j = 0; j < MA; j++) k2[((z*2+t)*MA+j)*8 +: 8] = 8'(weight(mode, t, z, j));
    for (int j = 0; j < MA; j++) k1[j*8 +: 8] = 8'(weight(mode, 0, 0, j));
  end

  convolution_2_5d dut4 (
    .clock(clock), .reset(reset), .pixel_vector_in(pv4), .kernel(k4), .pixel_vector_out(o4));
  convolution_2_5d #(.Z_DEPTH(2)) dut2 (
    .clock(clock), .reset(reset), .pixel_vector_in(pv2), .kernel(k2), .pixel_vector_out(o2));
  convolution_2_5d #(.NUM_TREES(1), .Z_DEPTH(1)) dut1 (
    .clock(clock), .reset(reset), .pixel_vector_in(pv1), .kernel(k1), .pixel_vector_out(o1));

  function automatic int model_sum(int t, int nz);
    int s;
    s = 0;
    for (int z = 0; z < nz; z++)
      for (int j = 0; j < MA; j++) s += hist[(j/P)*ROW_W + (j%P)] * weight(mode, t, z, j);
    return s;
  endfunction

  // One clock: drive inputs, advance the model, then pop and compare every output.
  task automatic step(input logic [7:0] p, input logic r);
    int e;
    pix   = p;
    reset = r;
    @(posedge clock);
    if (r) begin
      for (int k = 0; k < SR_LEN; k++) hist[k] = 0;
      q40 = {}; q41 = {}; q20 = {}; q21 = {}; q10 = {};
      for (int k = 0; k < LAT4; k++) begin q40.push_back(0); q41.push_back(0); end
      for (int k = 0; k < LAT2; k++) begin q20.push_back(0); q21.push_back(0); end
      for (int k = 0; k < LAT1; k++) q10.push_back(0);
    end else begin
      for (int k = SR_LEN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(p);
      q40.push_back(model_sum(0, 4));
      q41.push_back(model_sum(1, 4));
      q20.push_back(model_sum(0, 2));
      q21.push_back(model_sum(1, 2));
      q10.push_back(model_sum(0, 1));
    end
    @(negedge clock);
    cyc++;
    if (r) begin
      checks++;
      if ({o4, o2, o1} !== 160'd0) begin
        errors++;
        $display("FAIL reset_out cyc=%0d got o4=%h o2=%h o1=%h exp 0", cyc, o4, o2, o1);
      end
    end else begin
      e = q40.pop_front(); checks++;
      if ($signed(o4[31:0]) !== e) begin errors++; $display("FAIL sb_z4_t0 cyc=%0d got=%0d exp=%0d", cyc, $signed(o4[31:0]), e); end
      e = q41.pop_front(); checks++;
      if ($signed(o4[63:32]) !== e) begin errors++; $display("FAIL sb_z4_t1 cyc=%0d got=%0d exp=%0d", cyc, $signed(o4[63:32]), e); end
      e = q20.pop_front(); checks++;
      if ($signed(o2[31:0]) !== e) begin errors++; $display("FAIL sb_z2_t0 cyc=%0d got=%0d exp=%0d", cyc, $signed(o2[31:0]), e); end
      e = q21.pop_front(); checks++;
      if ($signed(o2[63:32]) !== e) begin errors++; $display("FAIL sb_z2_t1 cyc=%0d got=%0d exp=%0d", cyc, $signed(o2[63:32]), e); end
      e = q10.pop_front(); checks++;
      if ($signed(o1) !== e) begin errors++; $display("FAIL sb_z1_t0 cyc=%0d got=%0d exp=%0d", cyc, $signed(o1), e); end
    end
  endtask

  task automatic test_reset();
    mode = 0;
    step(8'd0, 1'b1);
    step(8'd7, 1'b1);
  endtask

  task automatic test_known_values();
    mode = 0;
    step(8'd0, 1'b1);
    for (int p = 0; p < 32; p++) begin
      step(8'(p), 1'b0);
      if (p == 21 + LAT4) begin
        checks += 2;
        if ($signed(o4[31:0]) !== 1596) begin errors++; $display("FAIL known_z4_t0_w21 got=%0d exp=1596", $signed(o4[31:0])); end
        if ($signed(o4[63:32]) !== 2428) begin errors++; $display("FAIL known_z4_t1_w21 got=%0d exp=2428", $signed(o4[63:32])); end
      end
      if (p == 22 + LAT4) begin
        checks += 2;
        if ($signed(o4[31:0]) !== 1748) begin errors++; $display("FAIL known_z4_t0_w22 got=%0d exp=1748", $signed(o4[31:0])); end
        if ($signed(o4[63:32]) !== 2660) begin errors++; $display("FAIL known_z4_t1_w22 got=%0d exp=2660", $signed(o4[63:32])); end
      end
      if (p == 21 + LAT2) begin
        checks += 2;
        if ($signed(o2[31:0]) !== 588) begin errors++; $display("FAIL known_z2_t0_w21 got=%0d exp=588", $signed(o2[31:0])); end
        if ($signed(o2[63:32]) !== 1084) begin errors++; $display("FAIL known_z2_t1_w21 got=%0d exp=1084", $signed(o2[63:32])); end
      end
      if (p == 22 + LAT2) begin
        checks += 2;
        if ($signed(o2[31:0]) !== 644) begin errors++; $display("FAIL known_z2_t0_w22 got=%0d exp=644", $signed(o2[31:0])); end
        if ($signed(o2[63:32]) !== 1188) begin errors++; $display("FAIL known_z2_t1_w22 got=%0d exp=1188", $signed(o2[63:32])); end
      end
      if (p == 21 + LAT1) begin
        checks++;
        if ($signed(o1) !== 84) begin errors++; $display("FAIL known_z1_w21 got=%0d exp=84", $signed(o1)); end
      end
      if (p == 22 + LAT1) begin
        checks++;
        if ($signed(o1) !== 92) begin errors++; $display("FAIL known_z1_w22 got=%0d exp=92", $signed(o1)); end
      end
    end
  endtask

  task automatic test_mid_reset();
    step(8'd50, 1'b0);
    step(8'd51, 1'b0);
    step(8'd52, 1'b1);
    for (int k = 1; k <= LAT4 + 1; k++) begin
      step((k == 1) ? 8'd100 : 8'd0, 1'b0);
      if (k <= LAT4) begin
        checks++;
        if (o4 !== 64'd0) begin errors++; $display("FAIL mid_reset_hold k=%0d got=%h exp=0", k, o4); end
      end else begin
        checks += 2;
        if ($signed(o4[31:0]) !== 1100) begin errors++; $display("FAIL mid_reset_first_t0 got=%0d exp=1100", $signed(o4[31:0])); end
        if ($signed(o4[63:32]) !== 1400) begin errors++; $display("FAIL mid_reset_first_t1 got=%0d exp=1400", $signed(o4[63:32])); end
      end
    end
  endtask

  task automatic test_sign_ext();
    mode = 1;
    step(8'd0, 1'b1);
    for (int k = 0; k < SR_LEN + LAT4 + 2; k++) step(8'd255, 1'b0);
    checks += 5;
    if ($signed(o4[31:0]) !== -16320) begin errors++; $display("FAIL neg_z4_t0 got=%0d exp=-16320", $signed(o4[31:0])); end
    if ($signed(o4[63:32]) !== -16320) begin errors++; $display("FAIL neg_z4_t1 got=%0d exp=-16320", $signed(o4[63:32])); end
    if ($signed(o2[31:0]) !== -8160) begin errors++; $display("FAIL neg_z2_t0 got=%0d exp=-8160", $signed(o2[31:0])); end
    if ($signed(o2[63:32]) !== -8160) begin errors++; $display("FAIL neg_z2_t1 got=%0d exp=-8160", $signed(o2[63:32])); end
    if ($signed(o1) !== -4080) begin errors++; $display("FAIL neg_z1 got=%0d exp=-4080", $signed(o1)); end
  endtask

  task automatic test_impulse();
    int nz4, nz2, nz1;
    nz4 = -1; nz2 = -1; nz1 = -1;
    mode = 0;
    step(8'd0, 1'b1);
    step(8'd5, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(8'd0, 1'b0);
      if (nz4 < 0 && o4 !== 64'd0) nz4 = k;
      if (nz2 < 0 && o2 !== 64'd0) nz2 = k;
      if (nz1 < 0 && o1 !== 32'd0) nz1 = k;
      if (k == LAT4) begin
        checks += 2;
        if ($signed(o4[31:0]) !== 55) begin errors++; $display("FAIL impulse_tap0_t0 got=%0d exp=55", $signed(o4[31:0])); end
        if ($signed(o4[63:32]) !== 70) begin errors++; $display("FAIL impulse_tap0_t1 got=%0d exp=70", $signed(o4[63:32])); end
      end
      if (k == LAT4 + 2) begin
        checks += 2;
        if ($signed(o4[31:0]) !== 40) begin errors++; $display("FAIL impulse_tap2_t0 got=%0d exp=40", $signed(o4[31:0])); end
        if ($signed(o4[63:32]) !== 75) begin errors++; $display("FAIL impulse_tap2_t1 got=%0d exp=75", $signed(o4[63:32])); end
      end
    end
    checks += 3;
    if (nz4 !== LAT4) begin errors++; $display("FAIL latency_z4 got=%0d exp=%0d", nz4, LAT4); end
    if (nz2 !== LAT2) begin errors++; $display("FAIL latency_z2 got=%0d exp=%0d", nz2, LAT2); end
    if (nz1 !== LAT1) begin errors++; $display("FAIL latency_z1 got=%0d exp=%0d", nz1, LAT1); end
  endtask

  task automatic test_back_to_back();
    mode = 0;
    step(8'd0, 1'b1);
    for (int k = 0; k < 80; k++) step(8'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    mode   = 0;
    reset  = 1'b1;
    pix    = 8'd0;
    test_reset();
    test_known_values();
    test_mid_reset();
    test_sign_ext();
    test_impulse();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
